car_collision_scanner: RTL and testbench
========================================

// Module: car_collision_scanner
// PURPOSE
//  Downstream consumer of the left-moving car generator's per-frame positions.
//  - On each frame_clk rising edge, snapshots all car boxes and the frog box.
//  - Scans the cars one per Clk cycle and reports a frog/car overlap.
//  - Maintains lives, an invulnerability window and game_over for the game FSM and HUD.
// PARAMETERS
//  NUM_CARS       6    cars scanned per frame (index width = $clog2(NUM_CARS))
//  CAR_W          24   car box width, pixels (box spans x .. x+CAR_W-1)
//  CAR_H          24   car box height, pixels
//  FROG_W         24   frog box width, pixels
//  FROG_H         24   frog box height, pixels
//  LIVES_INIT     3    lives loaded at reset (must be 1..15)
//  INVULN_FRAMES  60   frames in which hits are ignored after a hit (0 = none)
// PORTS
//  Clk        in   1            system clock, the only clock
//  Reset      in   1            asynchronous, active-high reset
//  frame_clk  in   1            frame strobe, sampled as data on Clk (not a clock here)
//  frog_x     in   32 signed    frog top-left x (int)
//  frog_y     in   32 signed    frog top-left y (int)
//  car_x      in   32s[NUM_CARS] car top-left x; may be negative near the wrap (>= -24)
//  car_y      in   32s[NUM_CARS] car top-left y
//  frog_hit   out  1            1-cycle pulse: hit accepted this frame
//  hit_car    out  $clog2(N)    lowest-index colliding car of last accepted hit
//  lives      out  4            remaining lives
//  game_over  out  1            level, set when lives reaches 0
//  busy       out  1            1 while in SCAN or REPORT
//  overrun    out  1            sticky; a frame edge was dropped
// BEHAVIOUR
//  Reset values
//  - frog_hit=0, hit_car=0, lives=LIVES_INIT, game_over=0, busy=0, overrun=0.
//  - FSM=IDLE; invulnerability counter=0; pending=0; frame_clk history register=0.
//  Frame-edge detection
//  - A frame edge is detected when frame_clk=1 and its registered value=0.
//  FSM: IDLE -> SCAN -> REPORT -> IDLE
//  - IDLE: on a frame edge (or pending=1), latch the car_*, frog_* snapshot; clear pending; idx=0; go to SCAN.
//  - SCAN: in each cycle, test car[idx] against the frog and OR the result into any_hit.
//    - first_idx records the first car with a hit.
//    - After idx=NUM_CARS-1, go to REPORT. SCAN lasts exactly NUM_CARS cycles.
//  - REPORT, single cycle:
//    - If any_hit && inv==0 && !game_over: frog_hit=1 and hit_car=first_idx.
//      lives decrements, saturating at 0; game_over=1 when the new value is 0; inv=INVULN_FRAMES.
//    - Otherwise: if inv>0, inv decrements.
//    - In both cases, go to IDLE.
//  - Latency: frog_hit asserts NUM_CARS+2 Clk cycles after the cycle in which the edge is sampled.
//  Overlap test, signed 32-bit arithmetic
//  - Hit if cx < fx+FROG_W, fx < cx+CAR_W, cy < fy+FROG_H and fy < cy+CAR_H.
//  - Boxes that only touch (for example cx+CAR_W == fx) do not hit.
//  Boundary conditions
//  - Frame edge while busy: set pending.
//    - If pending is already 1, the edge is dropped and overrun=1 (sticky until Reset).
//  - A pending frame starts in the cycle after REPORT.
//  - Inputs changing during SCAN have no effect; only the snapshot is used.
//  - Multiple simultaneous hits cost one life; hit_car is the lowest index.
//  - After game_over: no further decrement or frog_hit; scans still run.
//  - Reset asserted mid-SCAN aborts immediately to the reset values; no partial report.
// STRUCTURE
//  - froge_pkg holds:
//    - typedef int coord_t;
//    - typedef enum logic[1:0] {IDLE,SCAN,REPORT} scan_state_t;
//    - shared sprite sizes CAR_W/CAR_H/FROG_W/FROG_H.
//  - Sub-module box_overlap (combinational): two boxes -> hit. Instanced once and muxed by idx.
// TESTING
//  1 Reset; frog(300,300), all cars at y=100; frame edge -> frog_hit stays 0, busy for 7 cycles, lives=3.
//  2 car2=(290,296), frog(300,300); edge -> frog_hit pulse at edge+8, hit_car=2, lives=2.
//  3 cars 1 and 4 both overlap; edge -> a single pulse, hit_car=1, lives=1.
//  4 INVULN_FRAMES=2, permanent overlap; 4 edges -> hits on frames 1 and 4 only.
//  5 Edge case: car0=(-24,300), frog(0,300) -> no hit; car0=(-23,300) -> hit.
//  6 lives=1 and a hit -> lives=0, game_over=1, later hits give no pulse.
//    Then 3 edges within 4 cycles -> overrun=1.
//    Then Reset mid-SCAN -> all reset values.

Source files
------------

// File: rtl/froge_pkg.sv
// Shared types and sprite geometry for the frogger game blocks.
package froge_pkg;

    typedef int coord_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REPORT
    } scan_state_t;

    localparam int CAR_W  = 24;
    localparam int CAR_H  = 24;
    localparam int FROG_W = 24;
    localparam int FROG_H = 24;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/car_collision_scanner_if.sv
// Frame snapshot inputs and collision/HUD results of the car collision scanner.
interface car_collision_scanner_if #(
    parameter int NUM_CARS = 6
);
    import froge_pkg::*;

    localparam int IDX_W = idx_width(NUM_CARS);

    logic             frame_clk;
    coord_t           frog_x;
    coord_t           frog_y;
    coord_t           car_x [NUM_CARS];
    coord_t           car_y [NUM_CARS];
    logic             frog_hit;
    logic [IDX_W-1:0] hit_car;
    logic [3:0]       lives;
    logic             game_over;
    logic             busy;
    logic             overrun;

    modport master (
        output frame_clk, frog_x, frog_y, car_x, car_y,
        input  frog_hit, hit_car, lives, game_over, busy, overrun
    );

    modport slave (
        input  frame_clk, frog_x, frog_y, car_x, car_y,
        output frog_hit, hit_car, lives, game_over, busy, overrun
    );

endinterface

// File: rtl/car_collision_scanner_box_overlap.sv
// Combinational overlap test of two axis-aligned boxes; touching edges do not count.
module box_overlap
    import froge_pkg::*;
#(
    parameter int A_W = CAR_W,
    parameter int A_H = CAR_H,
    parameter int B_W = FROG_W,
    parameter int B_H = FROG_H
) (
    input  coord_t a_x,
    input  coord_t a_y,
    input  coord_t b_x,
    input  coord_t b_y,
    output logic   hit
);

    assign hit = (a_x < b_x + B_W) && (b_x < a_x + A_W) &&
                 (a_y < b_y + B_H) && (b_y < a_y + A_H);

endmodule

// File: rtl/car_collision_scanner.sv
// Snapshots car and frog boxes on each frame_clk edge, scans one car per cycle and
// maintains lives, the invulnerability window and game_over.
module car_collision_scanner
    import froge_pkg::*;
#(
    parameter int NUM_CARS      = 6,
    parameter int LIVES_INIT    = 3,
    parameter int INVULN_FRAMES = 60
) (
    input logic                    Clk,
    input logic                    Reset,
    car_collision_scanner_if.slave bus
);

    localparam int IDX_W = idx_width(NUM_CARS);
    localparam int INV_W = idx_width(INVULN_FRAMES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CARS - 1);

    scan_state_t      state_q, state_d;
    logic             frame_q;
    logic             edge_det;
    logic             pending_q;
    logic             overrun_q;
    logic             start;
    logic             scan_last;
    logic             accept;
    logic             busy;

    logic [IDX_W-1:0] idx_q;
    logic             any_hit_q;
    logic [IDX_W-1:0] first_idx_q;
    logic             car_hit;

    logic [INV_W-1:0] inv_q;
    logic [3:0]       lives_q;
    logic             game_over_q;
    logic             frog_hit_q;
    logic [IDX_W-1:0] hit_car_q;

    coord_t           snap_cx [NUM_CARS];
    coord_t           snap_cy [NUM_CARS];
    coord_t           snap_fx;
    coord_t           snap_fy;

    assign edge_det = bus.frame_clk & ~frame_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (scan_last) state_d = REPORT;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        start     = 1'b0;
        scan_last = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE:   start = edge_det || pending_q;
            SCAN: begin
                busy      = 1'b1;
                scan_last = (idx_q == LAST_IDX);
            end
            REPORT: begin
                busy   = 1'b1;
                accept = any_hit_q && (inv_q == '0) && !game_over_q;
            end
            default: ;
        endcase
    end

    // A second edge arriving while a frame is already queued is lost.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_q   <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            frame_q <= bus.frame_clk;
            if (!busy) begin
                pending_q <= pending_q && edge_det;
            end else if (edge_det) begin
                if (pending_q) overrun_q <= 1'b1;
                pending_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            idx_q       <= '0;
            any_hit_q   <= 1'b0;
            first_idx_q <= '0;
        end else if (start) begin
            idx_q       <= '0;
            any_hit_q   <= 1'b0;
            first_idx_q <= '0;
        end else if (state_q == SCAN) begin
            idx_q     <= idx_q + 1'b1;
            any_hit_q <= any_hit_q | car_hit;
            if (car_hit && !any_hit_q) first_idx_q <= idx_q;
        end
    end

    // NOTE: the snapshot is pure datapath, always loaded before it is read, so it carries no reset.
    always_ff @(posedge Clk) begin
        if (start) begin
            for (int i = 0; i < NUM_CARS; i++) begin
                snap_cx[i] <= bus.car_x[i];
                snap_cy[i] <= bus.car_y[i];
            end
            snap_fx <= bus.frog_x;
            snap_fy <= bus.frog_y;
        end
    end

    box_overlap #(
        .A_W(CAR_W),
        .A_H(CAR_H),
        .B_W(FROG_W),
        .B_H(FROG_H)
    ) u_overlap (
        .a_x(snap_cx[idx_q]),
        .a_y(snap_cy[idx_q]),
        .b_x(snap_fx),
        .b_y(snap_fy),
        .hit(car_hit)
    );

    // Results change only as REPORT closes, one cycle after the last car is tested.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frog_hit_q  <= 1'b0;
            hit_car_q   <= '0;
            lives_q     <= 4'(LIVES_INIT);
            game_over_q <= 1'b0;
            inv_q       <= '0;
        end else begin
            frog_hit_q <= accept;
            if (accept) begin
                hit_car_q   <= first_idx_q;
                lives_q     <= (lives_q == 4'd0) ? 4'd0 : lives_q - 4'd1;
                game_over_q <= (lives_q <= 4'd1);
                inv_q       <= INV_W'(INVULN_FRAMES);
            end else if (state_q == REPORT && inv_q != '0) begin
                inv_q <= inv_q - 1'b1;
            end
        end
    end

    assign bus.frog_hit  = frog_hit_q;
    assign bus.hit_car   = hit_car_q;
    assign bus.lives     = lives_q;
    assign bus.game_over = game_over_q;
    assign bus.busy      = busy;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_car_collision_scanner.sv
// Two scanners (60-frame and 2-frame invulnerability) driven by identical frames and
// compared against a frame-level model of hits, lives and invulnerability.
module tb_car_collision_scanner;
    import froge_pkg::*;

    localparam int NUM_CARS   = 6;
    localparam int LIVES_INIT = 3;
    localparam int INV_A      = 60;
    localparam int INV_B      = 2;
    localparam int IDX_W      = idx_width(NUM_CARS);

    logic   Clk = 1'b0;
    logic   Reset = 1'b1;
    logic   frame_clk = 1'b0;
    coord_t frog_x = 300;
    coord_t frog_y = 300;
    coord_t car_x [NUM_CARS];
    coord_t car_y [NUM_CARS];

    car_collision_scanner_if #(.NUM_CARS(NUM_CARS)) bus_a ();
    car_collision_scanner_if #(.NUM_CARS(NUM_CARS)) bus_b ();

    assign bus_a.frame_clk = frame_clk;
    assign bus_a.frog_x    = frog_x;
    assign bus_a.frog_y    = frog_y;
    assign bus_b.frame_clk = frame_clk;
    assign bus_b.frog_x    = frog_x;
    assign bus_b.frog_y    = frog_y;
    for (genvar g = 0; g < NUM_CARS; g++) begin : g_cars
        assign bus_a.car_x[g] = car_x[g];
        assign bus_a.car_y[g] = car_y[g];
        assign bus_b.car_x[g] = car_x[g];
        assign bus_b.car_y[g] = car_y[g];
    end

    car_collision_scanner #(
        .NUM_CARS(NUM_CARS), .LIVES_INIT(LIVES_INIT), .INVULN_FRAMES(INV_A)
    ) dut_a (
        .Clk(Clk), .Reset(Reset), .bus(bus_a)
    );

    car_collision_scanner #(
        .NUM_CARS(NUM_CARS), .LIVES_INIT(LIVES_INIT), .INVULN_FRAMES(INV_B)
    ) dut_b (
        .Clk(Clk), .Reset(Reset), .bus(bus_b)
    );

    always #5 Clk = ~Clk;

    logic [1:0]       hit_o, over_o, busy_o, ovr_o;
    logic [3:0]       lives_o [2];
    logic [IDX_W-1:0] car_o [2];
    assign hit_o      = {bus_b.frog_hit, bus_a.frog_hit};
    assign over_o     = {bus_b.game_over, bus_a.game_over};
    assign busy_o     = {bus_b.busy, bus_a.busy};
    assign ovr_o      = {bus_b.overrun, bus_a.overrun};
    assign lives_o[0] = bus_a.lives;
    assign lives_o[1] = bus_b.lives;
    assign car_o[0]   = bus_a.hit_car;
    assign car_o[1]   = bus_b.hit_car;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Frame-level model state, one slot per DUT.
    int m_lives [2];
    int m_inv [2];
    int m_hit_car [2];
    bit m_over [2];

    function automatic int inv_of(input int d);
        return (d == 0) ? INV_A : INV_B;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_lives[d]   = LIVES_INIT;
            m_inv[d]     = 0;
            m_hit_car[d] = 0;
            m_over[d]    = 1'b0;
        end
    endtask

    // Half-open spans [a0, a0+a_len) and [b0, b0+b_len) share at least one pixel.
    function automatic bit spans_meet(input int a0, input int a_len, input int b0, input int b_len);
        int lo, hi;
        lo = (a0 > b0) ? a0 : b0;
        hi = (a0 + a_len < b0 + b_len) ? a0 + a_len : b0 + b_len;
        return lo < hi;
    endfunction

    function automatic int first_hit();
        for (int i = 0; i < NUM_CARS; i++)
            if (spans_meet(car_x[i], CAR_W, frog_x, FROG_W) &&
                spans_meet(car_y[i], CAR_H, frog_y, FROG_H))
                return i;
        return -1;
    endfunction

    task automatic check_reset_values(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s/%0d frog_hit", tag, d), hit_o[d], 0);
            check($sformatf("%s/%0d hit_car", tag, d), car_o[d], 0);
            check($sformatf("%s/%0d lives", tag, d), lives_o[d], LIVES_INIT);
            check($sformatf("%s/%0d game_over", tag, d), over_o[d], 0);
            check($sformatf("%s/%0d busy", tag, d), busy_o[d], 0);
            check($sformatf("%s/%0d overrun", tag, d), ovr_o[d], 0);
        end
    endtask

    task automatic apply_reset(input string tag);
        @(negedge Clk);
        Reset     = 1'b1;
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
        check_reset_values(tag);
        Reset = 1'b0;
        model_reset();
    endtask

    // Frog at (300,300); cars parked on a row that can never reach it.
    task automatic scene_clear();
        frog_x = 300;
        frog_y = 300;
        for (int i = 0; i < NUM_CARS; i++) begin
            car_x[i] = int'($urandom_range(0, 663)) - 24;
            car_y[i] = int'($urandom_range(0, 200));
        end
    endtask

    task automatic scene_random(input int hit_pct);
        frog_x = int'($urandom_range(2, 600));
        frog_y = int'($urandom_range(2, 440));
        for (int i = 0; i < NUM_CARS; i++) begin
            if (int'($urandom_range(0, 99)) < hit_pct) begin
                car_x[i] = frog_x + int'($urandom_range(0, 52)) - 26;
                car_y[i] = frog_y + int'($urandom_range(0, 52)) - 26;
            end else begin
                car_x[i] = int'($urandom_range(0, 663)) - 24;
                car_y[i] = int'($urandom_range(0, 479));
            end
        end
    endtask

    // One frame: edge, 7 busy cycles, then the result at edge+8 checked against the model.
    task automatic run_frame(input string tag);
        int     exp_idx;
        bit     acc;
        coord_t sx [NUM_CARS];
        coord_t sy [NUM_CARS];
        coord_t sfx, sfy;
        exp_idx = first_hit();
        sfx = frog_x;
        sfy = frog_y;
        for (int i = 0; i < NUM_CARS; i++) begin
            sx[i] = car_x[i];
            sy[i] = car_y[i];
        end
        @(negedge Clk);
        frame_clk = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0;
        // Pile every car onto a moved frog; only the snapshot may count.
        frog_x = int'($urandom_range(0, 600));
        frog_y = int'($urandom_range(0, 440));
        for (int i = 0; i < NUM_CARS; i++) begin
            car_x[i] = frog_x;
            car_y[i] = frog_y;
        end
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) @(negedge Clk);
            for (int d = 0; d < 2; d++) begin
                check($sformatf("%s/%0d busy c%0d", tag, d, c), busy_o[d], 1);
                check($sformatf("%s/%0d early hit c%0d", tag, d, c), hit_o[d], 0);
            end
        end
        @(negedge Clk);
        for (int d = 0; d < 2; d++) begin
            acc = (exp_idx >= 0) && (m_inv[d] == 0) && !m_over[d];
            if (acc) begin
                m_lives[d]   = (m_lives[d] > 0) ? m_lives[d] - 1 : 0;
                m_over[d]    = (m_lives[d] == 0);
                m_inv[d]     = inv_of(d);
                m_hit_car[d] = exp_idx;
            end else if (m_inv[d] > 0) begin
                m_inv[d]--;
            end
            check($sformatf("%s/%0d frog_hit", tag, d), hit_o[d], acc);
            check($sformatf("%s/%0d busy end", tag, d), busy_o[d], 0);
            check($sformatf("%s/%0d lives", tag, d), lives_o[d], m_lives[d]);
            check($sformatf("%s/%0d game_over", tag, d), over_o[d], m_over[d]);
            check($sformatf("%s/%0d hit_car", tag, d), car_o[d], m_hit_car[d]);
            check($sformatf("%s/%0d overrun", tag, d), ovr_o[d], 0);
        end
        frog_x = sfx;
        frog_y = sfy;
        for (int i = 0; i < NUM_CARS; i++) begin
            car_x[i] = sx[i];
            car_y[i] = sy[i];
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        scene_clear();
        apply_reset("reset");

        // Phase A: quiet frame, single hit, drain invulnerability, double hit.
        run_frame("no_hit");
        scene_clear();
        car_x[2] = 290;
        car_y[2] = 296;
        run_frame("car2_hit");
        for (int k = 0; k < INV_A; k++) begin
            scene_clear();
            run_frame("drain_a");
        end
        scene_clear();
        car_x[1] = 310; car_y[1] = 310;
        car_x[4] = 280; car_y[4] = 290;
        run_frame("double_hit");

        // Phase B: touching versus overlapping at the wrap, then invulnerability window.
        scene_clear();
        apply_reset("reset_b");
        frog_x = 0;
        car_x[0] = -24; car_y[0] = 300;
        run_frame("touch_left");
        car_x[0] = -23;
        run_frame("overlap_left");
        for (int k = 0; k < INV_A; k++) begin
            scene_clear();
            run_frame("drain_b");
        end
        scene_clear();
        car_x[0] = 300; car_y[0] = 300;
        for (int k = 0; k < 4; k++) run_frame($sformatf("invuln_f%0d", k + 1));

        // Phase C: random frames, then play on until both scanners are out of lives.
        apply_reset("reset_c");
        for (int k = 0; k < 40; k++) begin
            scene_random(15);
            run_frame("random");
        end
        for (int k = 0; k < 250 && !(m_over[0] && m_over[1]); k++) begin
            scene_random(40);
            car_x[5] = frog_x + 5;
            car_y[5] = frog_y - 5;
            run_frame("to_game_over");
        end
        for (int d = 0; d < 2; d++) check($sformatf("game_over reached/%0d", d), over_o[d], 1);
        for (int k = 0; k < 3; k++) run_frame("after_game_over");

        // Second edge during a scan is queued and starts right after REPORT.
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
        repeat (5) @(negedge Clk);
        for (int d = 0; d < 2; d++) check($sformatf("pending gap busy/%0d", d), busy_o[d], 0);
        @(negedge Clk);
        for (int d = 0; d < 2; d++) check($sformatf("pending start busy/%0d", d), busy_o[d], 1);
        repeat (7) @(negedge Clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("pending done busy/%0d", d), busy_o[d], 0);
            check($sformatf("pending overrun/%0d", d), ovr_o[d], 0);
        end

        // Three edges within four cycles: the third is dropped.
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
        @(negedge Clk) frame_clk = 1'b1;
        for (int d = 0; d < 2; d++) check($sformatf("overrun before 3rd/%0d", d), ovr_o[d], 0);
        @(negedge Clk) frame_clk = 1'b0;
        for (int d = 0; d < 2; d++) check($sformatf("overrun set/%0d", d), ovr_o[d], 1);
        repeat (20) @(negedge Clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("overrun sticky/%0d", d), ovr_o[d], 1);
            check($sformatf("overrun idle/%0d", d), busy_o[d], 0);
            check($sformatf("overrun lives/%0d", d), lives_o[d], 0);
            check($sformatf("overrun game_over/%0d", d), over_o[d], 1);
        end

        // Reset in the middle of a scan that would have hit.
        scene_clear();
        car_x[3] = 300; car_y[3] = 300;
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
        @(negedge Clk);
        for (int d = 0; d < 2; d++) check($sformatf("mid_scan busy/%0d", d), busy_o[d], 1);
        #1 Reset = 1'b1;
        #1 check_reset_values("async_reset");
        @(negedge Clk) Reset = 1'b0;
        model_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            for (int d = 0; d < 2; d++) begin
                check($sformatf("no partial report/%0d c%0d", d, c), hit_o[d], 0);
                check($sformatf("post reset lives/%0d c%0d", d, c), lives_o[d], LIVES_INIT);
            end
        end
        run_frame("after_reset_hit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
